// File: rtl/dragon_pkg.sv
// dragon_pkg: shared grid geometry, food placement defaults and state encoding
package dragon_pkg;
  localparam int GRID_W = 80;
  localparam int GRID_H = 60;
  localparam int COORD_W = 7;
  localparam int DEF_X_MIN = 1;
  localparam int DEF_X_MAX = GRID_W - 2;
  localparam int DEF_Y_MIN = 1;
  localparam int DEF_Y_MAX = GRID_H - 2;
  typedef enum logic [1:0] {IDLE, SAMPLE, QUERY, WAIT} food_state_t;
endpackage

// File: rtl/food_placer.sv
// food_placer: samples random grid coordinates until an in-range, unoccupied cell is found
module food_placer
  import dragon_pkg::*;
#(
  parameter int X_MIN = DEF_X_MIN,
  parameter int X_MAX = DEF_X_MAX,
  parameter int Y_MIN = DEF_Y_MIN,
  parameter int Y_MAX = DEF_Y_MAX,
  parameter int MAX_TRIES = 8,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               place_req,
  input  logic [COORD_W-1:0] rand_X,
  input  logic [COORD_W-1:0] rand_Y,
  output logic               occ_query_valid,
  output logic [COORD_W-1:0] occ_query_X,
  output logic [COORD_W-1:0] occ_query_Y,
  input  logic               occ_resp_valid,
  input  logic               occ_hit,
  output logic               busy,
  output logic [COORD_W-1:0] food_X,
  output logic [COORD_W-1:0] food_Y,
  output logic               food_valid,
  output logic               place_done,
  output logic               place_fail
);
  localparam logic [COORD_W-1:0] XL = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] XH = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YL = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] YH = COORD_W'(Y_MAX);
  localparam logic [3:0] TRY_LIM = 4'(MAX_TRIES);
  localparam logic [4:0] TO_LIM = 5'(RESP_TIMEOUT - 1);
  food_state_t state, state_d;
  logic [COORD_W-1:0] cand_x, cand_y, fx_d, fy_d;
  logic [3:0] try_cnt, try_now;
  logic [4:0] to_cnt;
  logic in_rng, fail_try, exhaust, commit;
  logic query_d, done_d, fail_d, fvalid_d;
  // an X/Z sample never compares true, so it is rejected like any out-of-range value
  always_comb begin
    in_rng = ((rand_X >= XL) && (rand_X <= XH) && (rand_Y >= YL) && (rand_Y <= YH)) === 1'b1;
    try_now = state == SAMPLE ? try_cnt + 4'd1 : try_cnt;
    commit = state == WAIT && occ_resp_valid && !occ_hit;
    fail_try = state == SAMPLE ? !in_rng
             : state == WAIT && (occ_resp_valid ? occ_hit : to_cnt == TO_LIM);
    exhaust = fail_try && try_now == TRY_LIM;
  end
  always_comb begin
    state_d = state;
    if (clear) state_d = IDLE;
    else
      case (state)
        IDLE:    state_d = place_req ? SAMPLE : IDLE;
        SAMPLE:  state_d = in_rng ? QUERY : exhaust ? IDLE : SAMPLE;
        QUERY:   state_d = WAIT;
        WAIT:    state_d = (commit || exhaust) ? IDLE : fail_try ? SAMPLE : WAIT;
        default: state_d = IDLE;
      endcase
  end
  always_comb begin
    query_d = state_d == QUERY;
    done_d = !clear && commit;
    fail_d = !clear && exhaust;
    fvalid_d = clear ? 1'b0 : commit ? 1'b1 : food_valid;
    fx_d = done_d ? cand_x : food_X;
    fy_d = done_d ? cand_y : food_Y;
  end
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cand_x <= '0;
      cand_y <= '0;
      try_cnt <= '0;
      to_cnt <= '0;
      busy <= 1'b0;
      occ_query_valid <= 1'b0;
      place_done <= 1'b0;
      place_fail <= 1'b0;
      food_valid <= 1'b0;
      food_X <= '0;
      food_Y <= '0;
    end else begin
      state <= state_d;
      busy <= state_d != IDLE;
      occ_query_valid <= query_d;
      place_done <= done_d;
      place_fail <= fail_d;
      food_valid <= fvalid_d;
      food_X <= fx_d;
      food_Y <= fy_d;
      try_cnt <= state == IDLE ? 4'd0 : try_now;
      to_cnt <= state == WAIT ? to_cnt + 5'd1 : 5'd0;
      if (state == SAMPLE) begin
        cand_x <= rand_X;
        cand_y <= rand_Y;
      end
    end
  end
  assign occ_query_X = cand_x;
  assign occ_query_Y = cand_y;
endmodule
